mult_seq_ctrl: RTL and testbench

Sequential controller for an unsigned multiply that shares one carry-save reduction row across cycles instead of building a full partial-product tree. It accepts an operand pair over a valid/ready handshake and feeds one partial product per cycle into a 3:2 compressor row that accumulates into sum/carry registers. A single carry-propagate add then resolves the product, which is held on a valid/ready output port. It sits between the operand-issue logic and the result writeback in the multiplier datapath.

---
 rtl/mult_pkg.sv | 15 +
 rtl/csa_row.sv | 23 ++
 rtl/mult_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential multiplier.
//   mult_state_t : controller state encoding
//   MULT_WIDTH   : default operand width
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REDUCE  = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } mult_state_t;

endpackage

// File: rtl/csa_row.sv
// Combinational 3:2 compressor row. Three W-bit addends are reduced to a
// sum word and a carry word (carry already shifted into weight position).
// Ports:
//   x, y, z : addends
//   s       : bitwise sum
//   c       : majority carries shifted left by one, truncated to W bits
module csa_row #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    logic [W-1:0] maj;

    assign s   = x ^ y ^ z;
    assign maj = (x & y) | (x & z) | (y & z);
    assign c   = maj << 1;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential unsigned multiplier controller. Accepts an operand pair on a
// valid/ready port, accumulates one partial product per cycle through a
// single carry-save row, resolves sum+carry with one adder and holds the
// product on a valid/ready output port.
// Optional build macro: MULT_SEQ_SKIP_ZERO_EN -- stop reducing once the
// remaining multiplier bits are all zero (results unchanged, latency shrinks).
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   in_valid/in_ready       : operand handshake (ready only in IDLE)
//   in_a, in_b              : multiplicand, multiplier
//   out_valid/out_ready     : product handshake
//   out_product             : 2*WIDTH-bit unsigned product
//   busy                    : high while reducing or resolving
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mult_state_t     state;
    mult_state_t     next_state;

    logic [PW-1:0]    a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [PW-1:0]    sum;
    logic [PW-1:0]    carry;
    logic [SW-1:0]    step;

    logic [PW-1:0]    pp;
    logic [PW-1:0]    csa_s;
    logic [PW-1:0]    csa_c;
    logic             last_step;

    // Current partial product selected by the low multiplier bit.
    assign pp = b_sh[0] ? a_sh : '0;

    csa_row #(.W(PW)) u_csa_row (
        .x (sum),
        .y (carry),
        .z (pp),
        .s (csa_s),
        .c (csa_c)
    );

`ifdef MULT_SEQ_SKIP_ZERO_EN
    // Remaining multiplier bits exhausted: further rows add only zeros.
    assign last_step = (step == SW'(WIDTH - 1)) || ((b_sh >> 1) == '0);
`else
    assign last_step = (step == SW'(WIDTH - 1));
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef MULT_SEQ_SKIP_ZERO_EN
                    if (in_b == '0) begin
                        next_state = RESOLVE;
                    end else begin
                        next_state = REDUCE;
                    end
`else
                    next_state = REDUCE;
`endif
                end
            end
            REDUCE: begin
                if (last_step) begin
                    next_state = RESOLVE;
                end
            end
            RESOLVE: begin
                next_state = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Shift registers, carry-save accumulator and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            sum   <= '0;
            carry <= '0;
            step  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= PW'(in_a);
                        b_sh  <= in_b;
                        sum   <= '0;
                        carry <= '0;
                        step  <= '0;
                    end
                end
                REDUCE: begin
                    sum   <= csa_s;
                    carry <= csa_c;
                    a_sh  <= a_sh << 1;
                    b_sh  <= b_sh >> 1;
                    step  <= step + SW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Final carry-propagate add; carry-out cannot be set for a true product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_product <= '0;
        end else if (state == RESOLVE) begin
            out_product <= sum + carry;
        end
    end

    // Status outputs registered from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == DONE);
            busy      <= (next_state == REDUCE) || (next_state == RESOLVE);
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed cases, mid-operation reset
// and a randomized stream with output stalls checked against a queue of a*b.
module tb_mult_seq_ctrl;

    localparam int unsigned W    = 8;
    localparam int          NRND = 1000;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a      = '0;
    logic [W-1:0]   in_b      = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out_product;
    logic           busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Cycles from accept edge to out_valid, from the multiplier value alone.
    function automatic int exp_latency(input logic [W-1:0] b);
        int msb;
        int lat;
        msb = -1;
        for (int i = 0; i < int'(W); i++) begin
            if (b[i]) msb = i;
        end
        lat = int'(W) + 1;
`ifdef MULT_SEQ_SKIP_ZERO_EN
        lat = (msb < 0) ? 1 : msb + 2;
`endif
        return lat;
    endfunction

    // One directed operation; stall = cycles out_ready is held low after valid.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall, input string tag);
        int          k;
        int          g;
        logic [31:0] expp;
        expp      = 32'(a) * 32'(b);
        out_ready = (stall == 0);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_accept"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        check({tag, "_busy_run"}, 32'(busy), 32'd1);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'(exp_latency(b)));
        check({tag, "_product"}, 32'(out_product), expp);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_inready_done"}, 32'(in_ready), 32'd0);
        if (stall > 0) begin
            in_valid = 1'b1;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_product"}, 32'(out_product), expp);
                check({tag, "_hold_inready"}, 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_inready_after"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int n_rx;
        int k;
        int seen;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product", 32'(out_product), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed cases.
        do_op(8'd13, 8'd11, 0, "m13x11");
        do_op(8'hFF, 8'hFF, 0, "mFFxFF");
        do_op(8'h80, 8'h80, 0, "m80x80");
        do_op(8'h55, 8'h03, 0, "m55x03");
        do_op(8'h5A, 8'h00, 0, "m5Ax00");
        do_op(8'hC3, 8'hA7, 5, "stall");

        // Reset in the middle of a reduction.
        in_a = 8'd3; in_b = 8'hF5; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_product", 32'(out_product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_no_stale", 32'(out_valid), 32'd0);
        do_op(8'd7, 8'd6, 0, "after_rst");

        // Randomized back-to-back stream with output stalls.
        n_rx = 0;
        fork
            begin : driver
                for (int i = 0; i < NRND; i++) begin
                    int          g;
                    logic [W-1:0] a;
                    logic [W-1:0] b;
                    a = W'($urandom);
                    case ($urandom_range(0, 7))
                        0:       b = '0;
                        1:       b = '1;
                        2:       b = W'(1) << $urandom_range(0, W - 1);
                        default: b = W'($urandom);
                    endcase
                    in_a = a; in_b = b; in_valid = 1'b1;
                    g = 0;
                    while (!in_ready && g < 200) begin
                        @(negedge clk);
                        g++;
                    end
                    if (!in_ready) begin
                        check("rand_accept_timeout", 32'd0, 32'd1);
                        break;
                    end
                    exp_q.push_back(32'(a) * 32'(b));
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_a = W'($urandom);
                    in_b = W'($urandom);
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                end
            end
            begin : monitor
                int cyc;
                cyc = 0;
                while (n_rx < NRND && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rand_unexpected", 32'd1, 32'd0);
                        end else begin
                            check("rand_product", 32'(out_product), exp_q.pop_front());
                        end
                        n_rx++;
                    end
                end
            end
        join
        check("rand_count", 32'(n_rx), 32'(NRND));
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        // Nothing further may emerge once the stream is drained.
        out_ready = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rand_no_extra", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
